// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg: shared state encoding and limits for the pipelined N:1 selector
package mux_pipe_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    localparam int CNT_W      = 16;
    localparam int NUM_IN_MIN = 2;
    localparam int NUM_IN_MAX = 16;
endpackage

// File: rtl/mux_nx1.sv
// mux_nx1: combinational N:1 selector, zero on out-of-range select
module mux_nx1 #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [WIDTH-1:0]        o_data
);
    always_comb begin
        o_data = '0;
        for (int k = 0; k < NUM_IN; k++)
            if (i_sel == SEL_W'(k)) o_data = i_data[k*WIDTH +: WIDTH];
    end
endmodule

// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: N:1 select into a registered valid/ready stage with a one-entry skid
module mux_pipe_stage
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        xfer_cnt
);
    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
        $error("mux_pipe_stage: NUM_IN out of range");
    end

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_main_data, r_skid_data, w_sel_data;
    logic [SEL_W-1:0]   r_main_sel, r_skid_sel;
    logic               r_in_ready, r_sel_err;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_accept, w_pop, w_oor;

    mux_nx1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_mux (
        .i_data (in_data),
        .i_sel  (in_sel),
        .o_data (w_sel_data)
    );

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = (r_state != EMPTY) & out_ready;
    assign w_oor    = int'(in_sel) >= NUM_IN;

    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY:   w_next = w_accept ? ONE : EMPTY;
            ONE:     w_next = (w_accept && !w_pop) ? FULL : (w_pop && !w_accept) ? EMPTY : ONE;
            FULL:    w_next = w_pop ? ONE : FULL;
            default: w_next = EMPTY;
        endcase
        if (flush) w_next = EMPTY;
    end

    // in_ready is a register so that out_ready/in_valid never reach it combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_sel_err   <= 1'b0;
            r_cnt       <= '0;
            r_main_data <= '0;
            r_main_sel  <= '0;
            r_skid_data <= '0;
            r_skid_sel  <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != FULL);
            r_sel_err  <= w_accept & w_oor & !flush;
            if (w_accept && !flush) r_cnt <= r_cnt + 16'd1;
            if (flush) begin
                r_main_data <= '0;
                r_main_sel  <= '0;
                r_skid_data <= '0;
                r_skid_sel  <= '0;
            end else begin
                if (w_accept && (r_state == EMPTY || w_pop)) begin
                    r_main_data <= w_sel_data;
                    r_main_sel  <= in_sel;
                end else if (r_state == FULL && w_pop) begin
                    r_main_data <= r_skid_data;
                    r_main_sel  <= r_skid_sel;
                end
                if (w_accept && r_state == ONE && !w_pop) begin
                    r_skid_data <= w_sel_data;
                    r_skid_sel  <= in_sel;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_state != EMPTY;
    assign out_data  = r_main_data;
    assign out_sel   = r_main_sel;
    assign sel_err   = r_sel_err;
    assign xfer_cnt  = r_cnt;
endmodule

// File: tb/tb_mux_pipe_stage.sv
// tb_mux_pipe_stage: queue-scoreboard bench driving a 4-input and a 3-input stage in lockstep
module tb_mux_pipe_stage;
    logic        clk, rst_n, flush, in_valid, out_ready;
    logic [31:0] in_data4;
    logic [23:0] in_data3;
    logic [1:0]  in_sel;
    logic        in_ready4, in_ready3, out_valid4, out_valid3, sel_err4, sel_err3;
    logic [7:0]  out_data4, out_data3;
    logic [1:0]  out_sel4, out_sel3;
    logic [15:0] xfer4, xfer3;

    assign in_data3 = in_data4[23:0];

    mux_pipe_stage #(.WIDTH(8), .NUM_IN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data4), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4), .out_sel(out_sel4),
        .out_valid(out_valid4), .out_ready(out_ready), .sel_err(sel_err4), .xfer_cnt(xfer4)
    );

    mux_pipe_stage #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data3), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3), .out_sel(out_sel3),
        .out_valid(out_valid3), .out_ready(out_ready), .sel_err(sel_err3), .xfer_cnt(xfer3)
    );

    typedef struct {
        logic [7:0] d4;
        logic [7:0] d3;
        logic [1:0] sel;
    } item_t;

    item_t       q[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          cnt_m = 0;
    logic        exp_err = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst out_data4", 32'(out_data4), 0);
        check("rst out_data3", 32'(out_data3), 0);
        check("rst out_sel4", 32'(out_sel4), 0);
        check("rst out_valid4", 32'(out_valid4), 0);
        check("rst out_valid3", 32'(out_valid3), 0);
        check("rst in_ready4", 32'(in_ready4), 1);
        check("rst in_ready3", 32'(in_ready3), 1);
        check("rst sel_err3", 32'(sel_err3), 0);
        check("rst xfer4", 32'(xfer4), 0);
        check("rst xfer3", 32'(xfer3), 0);
    endtask

    // Model: a FIFO of up to two items; ready means fewer than two held
    always @(negedge clk) begin
        logic exp_ready, acc;
        item_t it;
        if (!rst_n) begin
            q.delete();
            cnt_m   = 0;
            exp_err = 1'b0;
        end else begin
            exp_ready = q.size() < 2;
            check("in_ready4", 32'(in_ready4), 32'(exp_ready));
            check("in_ready3", 32'(in_ready3), 32'(exp_ready));
            check("out_valid4", 32'(out_valid4), 32'(q.size() > 0));
            check("out_valid3", 32'(out_valid3), 32'(q.size() > 0));
            check("sel_err4", 32'(sel_err4), 0);
            check("sel_err3", 32'(sel_err3), 32'(exp_err));
            check("xfer4", 32'(xfer4), cnt_m & 32'hFFFF);
            check("xfer3", 32'(xfer3), cnt_m & 32'hFFFF);
            if (q.size() > 0) begin
                check("out_data4", 32'(out_data4), 32'(q[0].d4));
                check("out_data3", 32'(out_data3), 32'(q[0].d3));
                check("out_sel4", 32'(out_sel4), 32'(q[0].sel));
                check("out_sel3", 32'(out_sel3), 32'(q[0].sel));
                if (out_ready) void'(q.pop_front());
            end
            if (flush) q.delete();
            acc     = in_valid && exp_ready && !flush;
            exp_err = acc && in_sel == 2'd3;
            if (acc) begin
                it.d4  = in_data4[in_sel*8 +: 8];
                it.d3  = (in_sel == 2'd3) ? 8'h00 : it.d4;
                it.sel = in_sel;
                q.push_back(it);
                cnt_m++;
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_sel = 2'd0; in_data4 = 32'h44332211;
        repeat (3) step();
        check_reset_values();
        rst_n = 1'b1;
        step();
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        check("stream xfer4", 32'(xfer4), 4);
        // back-pressure: fill skid, then drain in order
        out_ready = 1'b0; in_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            in_sel = 2'(s);
            step();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        repeat (3) step();
        // out-of-range select on the 3-input instance
        in_sel = 2'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        // flush while full with a transfer offered
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
        repeat (3) step();
        flush = 1'b1; in_sel = 2'd2;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush out_valid", 32'(out_valid4), 0);
        check("flush in_ready", 32'(in_ready4), 1);
        out_ready = 1'b1;
        repeat (2) step();
        // asynchronous reset between edges mid-stream
        in_valid = 1'b1; in_sel = 2'd0;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        step();
        rst_n = 1'b1;
        in_sel = 2'd2;
        repeat (3) step();
        in_valid = 1'b0;
        step();
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_data4  = $urandom;
            in_sel    = 2'($urandom_range(0, 3));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 19) == 0;
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        // counter wrap
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; in_valid = 1'b1; in_sel = 2'd1;
        repeat (65537) step();
        in_valid = 1'b0;
        step();
        check("wrap xfer4", 32'(xfer4), 1);
        check("wrap xfer3", 32'(xfer3), 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
